bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It generalises the fixed 5-bit combinational converter to any input width, adds an optional two's-complement mode, and adds valid/ready handshakes on both sides. It feeds display and printout paths, where area matters more than latency.

---
 rtl/bin2bcd_pkg.sv | 29 ++
 rtl/bcd_add3_digit.sv | 12 +
 rtl/bin2bcd_seq.sv | 139 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD
// converter.
//   state_e      : converter FSM states
//   min_digits() : decimal digits needed to hold 2^bin_w - 1
//   cnt_width()  : width of the bit counter for a given input width
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BIN_W_DEF = 16;
  localparam int CNT_W_DEF = $clog2(BIN_W_DEF + 1);

  // 2^w is never a power of ten, so 2^w - 1 has the same digit count as 2^w,
  // i.e. floor(w * log10(2)) + 1. log10(2) ~= 0.30103.
  function automatic int min_digits(input int bin_w);
    longint unsigned scaled;
    scaled = longint'(bin_w) * 64'd30103;
    return int'(scaled / 64'd100000) + 1;
  endfunction

  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
//   digit_i : current BCD digit
//   digit_o : corrected digit, ready to be shifted
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with valid/ready handshakes on both sides and optional two's
// complement input (sign + magnitude output).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, bin_in captured on transfer
//   bin_in               : value to convert
//   out_valid/out_ready  : output handshake
//   bcd_out              : packed BCD result, digit 0 in [3:0]
//   sign_out             : negative input (SIGNED=1 only)
//   busy                 : conversion in progress
//
// state | meaning
// IDLE  | waiting for an input transfer
// SHIFT | one correction+shift per cycle, counter counts BIN_W down to 0
// DONE  | result held on bcd_out/sign_out until the consumer takes it
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int BCD_W = 4 * DIGITS;

  if (BIN_W < 2) begin : g_chk_bin_w
    $error("bin2bcd_seq: BIN_W must be at least 2");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_chk_digits
    $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W - 1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               sign_out_q, sign_out_d;

  logic               in_fire, out_fire;
  logic               last_bit;
  logic               neg_in;
  logic [BIN_W-1:0]   mag_in;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W+BIN_W-1:0] cat_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (work_q[4*g +: 4]),
      .digit_o (work_adj[4*g +: 4])
    );
  end

  // The corrected top digit never reaches 8 for a legal DIGITS, so the bit
  // shifted out of the top is always zero.
  assign cat_shift = {work_adj, mag_q} << 1;
  assign last_bit  = (cnt_q == CNT_W'(1));

  // Negating the most negative value wraps to 2^(BIN_W-1), which is the
  // correct magnitude when read as unsigned.
  assign neg_in = (SIGNED != 0) && bin_in[BIN_W-1];
  assign mag_in = neg_in ? (-bin_in) : bin_in;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      work_q     <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      sign_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      work_q     <= work_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      sign_out_q <= sign_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    work_d     = work_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    sign_out_d = sign_out_q;

    unique case (state_q)
      IDLE:  if (in_fire) state_d = SHIFT;
      SHIFT: if (last_bit) state_d = DONE;
      DONE:  if (out_fire) state_d = in_fire ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase

    if (in_fire) begin
      work_d = '0;
      mag_d  = mag_in;
      cnt_d  = CNT_W'(BIN_W);
      sign_d = neg_in;
    end else if (state_q == SHIFT) begin
      {work_d, mag_d} = cat_shift;
      cnt_d           = cnt_q - CNT_W'(1);
      if (last_bit) begin
        bcd_d      = cat_shift[BIN_W +: BCD_W];
        sign_out_d = sign_q;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT);
    bcd_out   = bcd_q;
    sign_out  = sign_out_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // unsigned 16-bit instance
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_sign, u_busy;
  logic [15:0] u_bin;
  logic [19:0] u_bcd;
  // signed 16-bit instance
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sign, s_busy;
  logic [15:0] s_bin;
  logic [19:0] s_bcd;
  // unsigned 5-bit instance
  logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_sign, t_busy;
  logic [4:0]  t_bin;
  logic [7:0]  t_bcd;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .bin_in(u_bin), .out_valid(u_out_valid), .out_ready(u_out_ready),
    .bcd_out(u_bcd), .sign_out(u_sign), .busy(u_busy));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .bin_in(s_bin), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .bcd_out(s_bcd), .sign_out(s_sign), .busy(s_busy));

  bin2bcd_seq #(.BIN_W(5), .DIGITS(2), .SIGNED(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .bin_in(t_bin), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .bcd_out(t_bcd), .sign_out(t_sign), .busy(t_busy));

  // Reference: decimal digits by plain division.
  function automatic logic [63:0] to_bcd(input longint unsigned v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture one value on the unsigned instance and check latency and result.
  task automatic run_u(input logic [15:0] v);
    int n;
    chk("u_in_ready_idle", u_in_ready, 1);
    u_bin = v;
    u_in_valid = 1'b1;
    step();
    u_in_valid = 1'b0;
    chk("u_busy", u_busy, 1);
    n = 0;
    while (!u_out_valid && n < 40) begin step(); n++; end
    chk("u_latency", n, 16);
    chk("u_bcd", u_bcd, to_bcd(64'(v)));
    chk("u_sign", u_sign, 0);
    step();
    chk("u_idle_after", u_out_valid, 0);
  endtask

  task automatic run_s(input logic [15:0] v);
    int n;
    int sv;
    sv = int'($signed(v));
    s_bin = v;
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 40) begin step(); n++; end
    chk("s_latency", n, 16);
    chk("s_sign", s_sign, (sv < 0) ? 1 : 0);
    chk("s_bcd", s_bcd, to_bcd(64'((sv < 0) ? -sv : sv)));
    step();
  endtask

  task automatic run_t(input int v);
    int n;
    t_bin = 5'(v);
    t_in_valid = 1'b1;
    step();
    t_in_valid = 1'b0;
    n = 0;
    while (!t_out_valid && n < 20) begin step(); n++; end
    chk("t_latency", n, 5);
    chk("t_bcd", t_bcd, 64'({4'(v / 10), 4'(v % 10)}));
    step();
  endtask

  initial begin
    int n;
    u_in_valid = 0; u_out_ready = 1; u_bin = '0;
    s_in_valid = 0; s_out_ready = 1; s_bin = '0;
    t_in_valid = 0; t_out_ready = 1; t_bin = '0;

    // reset state
    #3;
    chk("rst_out_valid", u_out_valid, 0);
    chk("rst_busy", u_busy, 0);
    chk("rst_bcd", u_bcd, 0);
    chk("rst_sign", s_sign, 0);
    chk("rst_in_ready", u_in_ready, 1);
    step(); step();
    rst_n = 1'b1;
    step();

    // directed unsigned values
    run_u(16'd65535);
    run_u(16'd0);
    run_u(16'd9);
    run_u(16'd10);

    // back-to-back with out_ready high
    u_bin = 16'd1234; u_in_valid = 1'b1;
    step();
    u_in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    u_bin = 16'd4321; u_in_valid = 1'b1;
    chk("b2b_shift_no_ready", u_in_ready, 0);
    step();
    chk("b2b_done_valid", u_out_valid, 1);
    chk("b2b_done_in_ready", u_in_ready, 1);
    chk("b2b_first", u_bcd, 64'h01234);
    step();
    u_in_valid = 1'b0;
    chk("b2b_recapture_busy", u_busy, 1);
    n = 1;
    while (!u_out_valid && n < 40) begin step(); n++; end
    chk("b2b_spacing", n, 17);
    chk("b2b_second", u_bcd, 64'h04321);
    step();

    // backpressure
    u_out_ready = 1'b0;
    u_bin = 16'd31; u_in_valid = 1'b1;
    step();
    u_in_valid = 1'b0;
    n = 0;
    while (!u_out_valid && n < 40) begin step(); n++; end
    chk("bp_latency", n, 16);
    u_bin = 16'd999; u_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready", u_in_ready, 0);
      step();
      chk("bp_hold_valid", u_out_valid, 1);
      chk("bp_hold_bcd", u_bcd, 64'h00031);
    end
    u_in_valid = 1'b0;
    u_out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", u_in_ready, 1);
    step();
    chk("bp_released", u_out_valid, 0);
    chk("bp_idle_busy", u_busy, 0);
    chk("bp_idle_ready", u_in_ready, 1);

    // reset in the middle of a conversion
    u_bin = 16'd12345; u_in_valid = 1'b1;
    step();
    u_in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_busy_before", u_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", u_out_valid, 0);
    chk("mid_rst_bcd", u_bcd, 0);
    chk("mid_rst_busy", u_busy, 0);
    #2;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (u_out_valid) n++;
    end
    chk("mid_no_pulse", n, 0);
    run_u(16'd500);

    // random unsigned
    for (int i = 0; i < 20; i++) run_u(16'($urandom_range(65535)));

    // signed directed and random
    run_s(16'h8000);
    run_s(16'hFFFF);
    run_s(16'd32767);
    run_s(16'd0);
    for (int i = 0; i < 12; i++) run_s(16'($urandom));

    // exhaustive 5-bit sweep
    for (int v = 0; v < 32; v++) run_t(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
